bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Parametrised successor to the core's fixed fetch/data bus mux.
- Arbitrates NUM_MASTERS requesters (fetch stage, memory stage, future DMA/debug) onto the single 32-bit bus.
- Adds a ready/acknowledge handshake with wait states, byte-lane steering, alignment checking, a bus timeout, and selectable fixed or round-robin priority.
- Sits between the pipeline stages and the external bus, replacing the combinational select.

Parameters:
NUM_MASTERS, 2, number of requesting masters; index 0 is highest fixed priority.
TIMEOUT_CYCLES, 15, wait-state cycles tolerated in ACCESS before a timeout error; must be at least 1.
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last granted master.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
master_request  input  NUM_MASTERS  per-master request, held until done or error.
master_write  input  NUM_MASTERS  1 = write, 0 = read.
master_address  input  NUM_MASTERS*32  byte address per master, master i at bits [32i+31:32i].
master_cycle_width  input  NUM_MASTERS*2  t_cycle_width per master (CW_BYTE, CW_WORD, CW_LONG).
master_data_out  input  NUM_MASTERS*32  right-aligned write data per master.
master_data_in  output  32  right-aligned, zero-extended read data; valid in the master_done cycle.
master_grant  output  NUM_MASTERS  one-hot; winner held from the ACCESS entry cycle through to done or error.
master_done  output  NUM_MASTERS  one-cycle pulse to the granted master on successful completion.
master_error  output  NUM_MASTERS  one-cycle pulse on misalignment, bus fault or timeout.
bus_address  output  30  long-word address [31:2].
bus_data_out  output  32  lane-steered write data.
bus_data_strobes  output  4  active-high byte lanes; bit 3 = bits 31:24.
bus_read  output  1  read cycle active.
bus_write  output  1  write cycle active.
bus_ack  input  1  slave completes the cycle this clock.
bus_fault  input  1  slave signals an error this clock; takes precedence over bus_ack.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - All outputs go to 0; state goes to IDLE.
  - Round-robin pointer goes to NUM_MASTERS-1, so master 0 is searched first.
  - Timeout counter goes to 0.
- States: IDLE, ACCESS, FINISH. All outputs are registered.
- IDLE:
  - If any request is set, pick the winner by the priority rule.
  - Latch the winner's address, width, direction and data.
  - Check alignment:
    - CW_BYTE: any address is legal.
    - CW_WORD: address[0] must be 0.
    - CW_LONG: address[1:0] must be 00.
  - Aligned: drive bus signals and master_grant next cycle, enter ACCESS.
  - Misaligned: no bus cycle; pulse master_error next cycle, enter FINISH.
- Strobes (big-endian):
  - Byte: addr[1:0] = 00/01/10/11 gives 1000/0100/0010/0001.
  - Word: addr[1] = 0 gives 1100; addr[1] = 1 gives 0011.
  - Long: 1111.
- Write data is replicated to all lanes (byte x4, word x2); unstrobed lanes are don't-care.
- Read data is shifted from the strobed lanes to bits [7:0] or [15:0] and zero-extended.
- ACCESS:
  - bus_read or bus_write, address and strobes are held stable every cycle.
  - The counter increments every cycle in ACCESS.
  - bus_fault: pulse master_error, deassert the bus, enter FINISH.
  - Else bus_ack: capture master_data_in, pulse master_done, deassert the bus, enter FINISH.
  - Else counter == TIMEOUT_CYCLES: treat as a fault.
- FINISH:
  - Single cycle. Grant clears; the done/error pulse ends; the round-robin pointer updates to the granted index.
  - Returns to IDLE. A one-cycle bus turnaround is guaranteed between transactions.
- Latency: request seen at edge 0 → bus active after edge 1 → ack at edge 2 → done visible after edge 2. Minimum 3 cycles per transaction.
- A master dropping its request mid-ACCESS is ignored; the transaction completes or fails normally.
- Requests from non-granted masters are held off (no grant) until IDLE.
- An error pulse never coincides with a done pulse.

Decomposition:
- Shared package (businterface.vh): t_cycle_width with CW_BYTE=2'b00, CW_WORD=2'b01, CW_LONG=2'b10.
- Shared package: t_arb_state enum (IDLE, ACCESS, FINISH).
- One sub-module: bus_arbiter_picker.
  - Combinational fixed or round-robin one-hot selector.
  - Inputs: request vector, last-grant pointer, mode.
  - Outputs: one-hot winner and binary index.

Test Plan:
- Master 1 long read at 0x00001004, bus_ack on the first ACCESS cycle, data 0xDEADBEEF → bus_address=0x401, strobes 1111, master_done[1] pulse, master_data_in=0xDEADBEEF, 3 cycles total.
- Master 0 byte write 0x5A at 0x00000102, 2 wait states → strobes 0010, bus_data_out=0x5A5A5A5A, done after 5 cycles.
- Word read at address 0x00000003 → no bus_read ever asserted, master_error[0] one pulse.
- Both masters request continuously with ROUND_ROBIN=1 → grants alternate 0,1,0,1; with ROUND_ROBIN=0 master 0 wins every time.
- Slave never acks, TIMEOUT_CYCLES=15 → master_error after the 15th ACCESS cycle, bus deasserted; bus_fault with bus_ack together → error only.
- Reset asserted mid-ACCESS → all outputs 0 without waiting for a clock; next request starts cleanly from master 0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and lane-steering helpers for the multi-master bus arbiter.
// Cycle widths match the core's existing bus interface encoding.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        CW_BYTE = 2'b00,
        CW_WORD = 2'b01,
        CW_LONG = 2'b10
    } t_cycle_width;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        FINISH
    } t_arb_state;

    localparam int DATA_W = 32;
    localparam int BADDR_W = 30;
    localparam int LANES = 4;

    function automatic logic is_aligned(
        input t_cycle_width cw,
        input logic [1:0]   lo
    );
        logic ok;
        case (cw)
            CW_BYTE: ok = 1'b1;
            CW_WORD: ok = ~lo[0];
            CW_LONG: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Big-endian lanes: byte 0 of a long word lives on bits 31:24.
    function automatic logic [LANES-1:0] lane_strobes(
        input t_cycle_width cw,
        input logic [1:0]   lo
    );
        logic [LANES-1:0] s;
        case (cw)
            CW_BYTE: s = 4'b1000 >> lo;
            CW_WORD: s = lo[1] ? 4'b0011 : 4'b1100;
            CW_LONG: s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(
        input t_cycle_width      cw,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] r;
        case (cw)
            CW_BYTE: r = {4{d[7:0]}};
            CW_WORD: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] extract(
        input t_cycle_width      cw,
        input logic [1:0]        lo,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] sh;
        sh = d >> {2'd3 - lo, 3'b000};
        case (cw)
            CW_BYTE: r = {24'b0, sh[7:0]};
            CW_WORD: r = lo[1] ? {16'b0, d[15:0]} : {16'b0, d[31:16]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request bundle and external bus signals of the arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    master_request;
    logic [NUM_MASTERS-1:0]    master_write;
    logic [NUM_MASTERS*32-1:0] master_address;
    logic [NUM_MASTERS*2-1:0]  master_cycle_width;
    logic [NUM_MASTERS*32-1:0] master_data_out;
    logic [31:0]               master_data_in;
    logic [NUM_MASTERS-1:0]    master_grant;
    logic [NUM_MASTERS-1:0]    master_done;
    logic [NUM_MASTERS-1:0]    master_error;

    logic [29:0]               bus_address;
    logic [31:0]               bus_data_out;
    logic [31:0]               bus_data_in;
    logic [3:0]                bus_data_strobes;
    logic                      bus_read;
    logic                      bus_write;
    logic                      bus_ack;
    logic                      bus_fault;

    modport master (
        input  master_request, master_write, master_address,
        input  master_cycle_width, master_data_out,
        output master_data_in, master_grant, master_done, master_error,
        output bus_address, bus_data_out, bus_data_strobes,
        output bus_read, bus_write,
        input  bus_data_in, bus_ack, bus_fault
    );

    modport slave (
        output master_request, master_write, master_address,
        output master_cycle_width, master_data_out,
        input  master_data_in, master_grant, master_done, master_error,
        input  bus_address, bus_data_out, bus_data_strobes,
        input  bus_read, bus_write,
        output bus_data_in, bus_ack, bus_fault
    );
endinterface

// File: rtl/bus_arbiter_picker.sv
// Combinational winner selection: fixed (lowest index) or round-robin
// starting one past the last granted master.
module bus_arbiter_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IDX_W-1:0]       last,
    input  logic                   round_robin,
    output logic [NUM_MASTERS-1:0] win_oh,
    output logic [IDX_W-1:0]       win_idx
);
    always_comb begin
        int   c;
        logic found;
        c = 0;
        found = 1'b0;
        win_oh = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            c = round_robin ? (int'(last) + 1 + k) % NUM_MASTERS : k;
            if (!found && request[IDX_W'(c)]) begin
                found = 1'b1;
                win_oh[IDX_W'(c)] = 1'b1;
                win_idx = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Multi-master arbiter onto the single 32-bit bus with wait states,
// byte-lane steering, alignment check and a wait-state timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ROUND_ROBIN    = 0
) (
    input logic           clock,
    input logic           reset,
    bus_arbiter_if.master bif
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_MASTERS - 1);

    t_arb_state             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    t_cycle_width           cw_q, cw_d;
    logic [1:0]             lo_q, lo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] done_q, done_d;
    logic [NUM_MASTERS-1:0] error_q, error_d;
    logic [31:0]            data_in_q, data_in_d;
    logic [29:0]            baddr_q, baddr_d;
    logic [31:0]            bdout_q, bdout_d;
    logic [3:0]             strb_q, strb_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;

    logic [NUM_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic [31:0]            w_addr;
    logic [31:0]            w_data;
    t_cycle_width           w_cw;
    logic                   w_write;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   timed_out;

    bus_arbiter_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .request     (bif.master_request),
        .last        (ptr_q),
        .round_robin (ROUND_ROBIN != 0),
        .win_oh      (win_oh),
        .win_idx     (win_idx)
    );

    always_comb begin
        w_addr = bif.master_address[32*win_idx +: 32];
        w_data = bif.master_data_out[32*win_idx +: 32];
        w_cw = t_cycle_width'(bif.master_cycle_width[2*win_idx +: 2]);
        w_write = bif.master_write[win_idx];
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    // An ack in the final allowed wait state still wins over the timeout.
    assign timed_out = !bif.bus_ack && (cnt_inc == CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        cw_d = cw_q;
        lo_d = lo_q;
        cnt_d = cnt_q;
        grant_d = grant_q;
        done_d = done_q;
        error_d = error_q;
        data_in_d = data_in_q;
        baddr_d = baddr_q;
        bdout_d = bdout_q;
        strb_d = strb_q;
        rd_d = rd_q;
        wr_d = wr_q;
        unique case (state_q)
            IDLE: begin
                if (|bif.master_request) begin
                    idx_d = win_idx;
                    cw_d = w_cw;
                    lo_d = w_addr[1:0];
                    cnt_d = '0;
                    if (is_aligned(w_cw, w_addr[1:0])) begin
                        baddr_d = w_addr[31:2];
                        bdout_d = replicate(w_cw, w_data);
                        strb_d = lane_strobes(w_cw, w_addr[1:0]);
                        rd_d = !w_write;
                        wr_d = w_write;
                        grant_d = win_oh;
                        state_d = ACCESS;
                    end else begin
                        error_d = win_oh;
                        state_d = FINISH;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                if (bif.bus_fault || timed_out) begin
                    error_d = grant_q;
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    strb_d = '0;
                    state_d = FINISH;
                end else if (bif.bus_ack) begin
                    data_in_d = extract(cw_q, lo_q, bif.bus_data_in);
                    done_d = grant_q;
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    strb_d = '0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                grant_d = '0;
                done_d = '0;
                error_d = '0;
                ptr_d = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= PTR_INIT;
            idx_q <= '0;
            cw_q <= CW_BYTE;
            lo_q <= '0;
            cnt_q <= '0;
            grant_q <= '0;
            done_q <= '0;
            error_q <= '0;
            data_in_q <= '0;
            baddr_q <= '0;
            bdout_q <= '0;
            strb_q <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            cw_q <= cw_d;
            lo_q <= lo_d;
            cnt_q <= cnt_d;
            grant_q <= grant_d;
            done_q <= done_d;
            error_q <= error_d;
            data_in_q <= data_in_d;
            baddr_q <= baddr_d;
            bdout_q <= bdout_d;
            strb_q <= strb_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    assign bif.master_data_in = data_in_q;
    assign bif.master_grant = grant_q;
    assign bif.master_done = done_q;
    assign bif.master_error = error_q;
    assign bif.bus_address = baddr_q;
    assign bif.bus_data_out = bdout_q;
    assign bif.bus_data_strobes = strb_q;
    assign bif.bus_read = rd_q;
    assign bif.bus_write = wr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: one round-robin arbiter and one fixed-priority arbiter
// driven with identical stimulus; expected values are hand-derived.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [3:0]  cw;
    logic [63:0] dout;
    logic [31:0] bdin;
    logic        ack;
    logic        fault;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    bus_arbiter_if #(.NUM_MASTERS(2)) ifa ();
    bus_arbiter_if #(.NUM_MASTERS(2)) ifb ();

    assign ifa.master_request = req;
    assign ifa.master_write = wr;
    assign ifa.master_address = addr;
    assign ifa.master_cycle_width = cw;
    assign ifa.master_data_out = dout;
    assign ifa.bus_data_in = bdin;
    assign ifa.bus_ack = ack;
    assign ifa.bus_fault = fault;
    assign ifb.master_request = req;
    assign ifb.master_write = wr;
    assign ifb.master_address = addr;
    assign ifb.master_cycle_width = cw;
    assign ifb.master_data_out = dout;
    assign ifb.bus_data_in = bdin;
    assign ifb.bus_ack = ack;
    assign ifb.bus_fault = fault;

    bus_arbiter #(
        .NUM_MASTERS(2), .TIMEOUT_CYCLES(15), .ROUND_ROBIN(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bif   (ifa.master)
    );

    bus_arbiter #(
        .NUM_MASTERS(2), .TIMEOUT_CYCLES(15), .ROUND_ROBIN(0)
    ) dut_fx (
        .clock (clock),
        .reset (reset),
        .bif   (ifb.master)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic w, input logic [31:0] a,
                         input logic [1:0] c, input logic [31:0] d);
        wr[i] = w;
        addr[i*32 +: 32] = a;
        cw[i*2 +: 2] = c;
        dout[i*32 +: 32] = d;
    endtask

    logic [1:0] exp_rr [4];

    initial begin
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset = 1'b1;
        req = '0; wr = '0; addr = '0; cw = '0; dout = '0;
        bdin = '0; ack = 1'b0; fault = 1'b0;
        step();
        step();
        chk("rst_grant", ifa.master_grant, 0);
        chk("rst_read", ifa.bus_read, 0);
        chk("rst_write", ifa.bus_write, 0);
        chk("rst_strb", ifa.bus_data_strobes, 0);
        chk("rst_addr", ifa.bus_address, 0);
        reset = 1'b0;

        // master 1 long read, ack on first ACCESS cycle
        set_m(1, 1'b0, 32'h0000_1004, CW_LONG, 32'h0);
        req = 2'b10; bdin = 32'hDEAD_BEEF; ack = 1'b1;
        step();
        chk("t1_read", ifa.bus_read, 1);
        chk("t1_addr", ifa.bus_address, 32'h401);
        chk("t1_strb", ifa.bus_data_strobes, 4'b1111);
        chk("t1_grant", ifa.master_grant, 2'b10);
        chk("t1_done_early", ifa.master_done, 0);
        step();
        chk("t1_done", ifa.master_done, 2'b10);
        chk("t1_data", ifa.master_data_in, 32'hDEAD_BEEF);
        chk("t1_bus_off", ifa.bus_read, 0);
        req = 2'b00; ack = 1'b0;
        step();
        chk("t1_done_end", ifa.master_done, 0);
        chk("t1_grant_end", ifa.master_grant, 0);

        // master 0 byte write with two wait states
        set_m(0, 1'b1, 32'h0000_0102, CW_BYTE, 32'h0000_005A);
        req = 2'b01;
        step();
        chk("t2_write", ifa.bus_write, 1);
        chk("t2_strb", ifa.bus_data_strobes, 4'b0010);
        chk("t2_dout", ifa.bus_data_out, 32'h5A5A_5A5A);
        chk("t2_addr", ifa.bus_address, 32'h40);
        step();
        chk("t2_wait1", ifa.bus_write, 1);
        chk("t2_wait1_done", ifa.master_done, 0);
        step();
        chk("t2_wait2_strb", ifa.bus_data_strobes, 4'b0010);
        ack = 1'b1;
        step();
        chk("t2_done", ifa.master_done, 2'b01);
        chk("t2_bus_off", ifa.bus_write, 0);
        req = 2'b00; ack = 1'b0;
        step();

        // misaligned word read by master 0
        set_m(0, 1'b0, 32'h0000_0003, CW_WORD, 32'h0);
        req = 2'b01;
        step();
        chk("t3_error", ifa.master_error, 2'b01);
        chk("t3_no_read", ifa.bus_read, 0);
        chk("t3_no_grant", ifa.master_grant, 0);
        chk("t3_no_done", ifa.master_done, 0);
        req = 2'b00;
        step();
        chk("t3_error_end", ifa.master_error, 0);
        chk("t3_still_idle", ifa.bus_read, 0);

        // byte read from lane 2 (addr ..01)
        set_m(0, 1'b0, 32'h0000_0101, CW_BYTE, 32'h0);
        req = 2'b01; bdin = 32'h1122_3344; ack = 1'b1;
        step();
        chk("t4_strb", ifa.bus_data_strobes, 4'b0100);
        step();
        chk("t4_data", ifa.master_data_in, 32'h0000_0022);
        req = 2'b00; ack = 1'b0;
        step();

        // word read from low half by master 1
        set_m(1, 1'b0, 32'h0000_2002, CW_WORD, 32'h0);
        req = 2'b10; bdin = 32'hAABB_CCDD; ack = 1'b1;
        step();
        chk("t5_strb", ifa.bus_data_strobes, 4'b0011);
        chk("t5_addr", ifa.bus_address, 32'h800);
        step();
        chk("t5_data", ifa.master_data_in, 32'h0000_CCDD);
        chk("t5_done", ifa.master_done, 2'b10);
        req = 2'b00; ack = 1'b0;
        step();

        // both masters request continuously
        set_m(0, 1'b0, 32'h0000_0010, CW_LONG, 32'h0);
        set_m(1, 1'b0, 32'h0000_0020, CW_LONG, 32'h0);
        req = 2'b11; ack = 1'b1; bdin = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant", ifa.master_grant, exp_rr[k]);
            chk("rr_addr", ifa.bus_address,
                (exp_rr[k] == 2'b01) ? 32'h4 : 32'h8);
            chk("fx_grant", ifb.master_grant, 2'b01);
            step();
            chk("rr_done", ifa.master_done, exp_rr[k]);
            step();
        end
        req = 2'b00; ack = 1'b0;

        // fault together with ack on a master 1 write
        set_m(1, 1'b1, 32'h0000_0080, CW_LONG, 32'h1234_5678);
        req = 2'b10; ack = 1'b1; fault = 1'b1;
        step();
        chk("t6_write", ifa.bus_write, 1);
        chk("t6_dout", ifa.bus_data_out, 32'h1234_5678);
        step();
        chk("t6_error", ifa.master_error, 2'b10);
        chk("t6_no_done", ifa.master_done, 0);
        chk("t6_bus_off", ifa.bus_write, 0);
        req = 2'b00; ack = 1'b0; fault = 1'b0;
        step();

        // slave never acks: timeout after the 15th ACCESS cycle
        set_m(0, 1'b0, 32'h0000_0040, CW_LONG, 32'h0);
        req = 2'b01;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("t7_read_15", ifa.bus_read, 1);
        chk("t7_no_err_15", ifa.master_error, 0);
        step();
        chk("t7_error", ifa.master_error, 2'b01);
        chk("t7_bus_off", ifa.bus_read, 0);
        chk("t7_no_done", ifa.master_done, 0);
        req = 2'b00;
        step();
        chk("t7_error_end", ifa.master_error, 0);

        // asynchronous reset in the middle of ACCESS
        set_m(0, 1'b0, 32'h0000_0010, CW_LONG, 32'h0);
        req = 2'b01;
        step();
        chk("t8_read", ifa.bus_read, 1);
        #2 reset = 1'b1;
        #1;
        chk("t8_rst_read", ifa.bus_read, 0);
        chk("t8_rst_grant", ifa.master_grant, 0);
        chk("t8_rst_strb", ifa.bus_data_strobes, 0);
        chk("t8_rst_addr", ifa.bus_address, 0);
        chk("t8_rst_data", ifa.master_data_in, 0);
        #2 reset = 1'b0;
        req = 2'b11; ack = 1'b1;
        step();
        chk("t8_restart_grant", ifa.master_grant, 2'b01);
        chk("t8_restart_addr", ifa.bus_address, 32'h4);
        step();
        chk("t8_restart_done", ifa.master_done, 2'b01);
        req = 2'b00; ack = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
